// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt controller sequencer.
// Init/ack state encodings, OCW2 opcodes and ICW field positions.
package pic_pkg;

  typedef enum logic [2:0] {
    S_WAIT1,
    S_ICW2,
    S_ICW3,
    S_ICW4,
    S_READY
  } init_st_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_ACK1,
    A_ACK2
  } ack_st_t;

  localparam logic [2:0] EOI_NS  = 3'b001;
  localparam logic [2:0] EOI_SP  = 3'b011;
  localparam logic [2:0] ROT_NS  = 3'b101;
  localparam logic [2:0] SET_PRI = 3'b110;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int ICW4_AEOI = 1;

endpackage

// File: rtl/prio_rotate.sv
// Rotating priority resolver: highest-priority set bit of vec,
// where priority starts at (lp+1) mod N_IRQ and wraps.
module prio_rotate #(
  parameter int N_IRQ = 8,
  localparam int IDX_W = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] vec,
  input  logic [IDX_W-1:0] lp,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int j;

  // Scan lowest to highest priority so the last hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N_IRQ; k >= 1; k--) begin
      j = (int'(lp) + k) % N_IRQ;
      if (vec[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/pic_ctrl_seq.sv
// Interrupt controller core: IRR/ISR/IMR, ICW init FSM, OCW decode,
// rotating priority and the two-pulse INTA vector sequence.
module pic_ctrl_seq
  import pic_pkg::*;
#(
  parameter int N_IRQ = 8,
  localparam int IDX_W = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             a0,
  input  logic [7:0]       wdata,
  input  logic             rd_en,
  output logic [7:0]       rdata,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             inta_n,
  output logic             int_out,
  output logic [7:0]       vec_out,
  output logic             vec_valid,
  output logic             data_dir,
  output logic             init_done
);

  localparam logic [IDX_W-1:0] LP_RST = IDX_W'(N_IRQ - 1);

  init_st_t init_st_q, init_st_d;
  ack_st_t  ack_st_q, ack_st_d;

  logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d;
  logic [7:0] icw3_q, icw3_d, icw4_q, icw4_d;

  logic [N_IRQ-1:0] irr_q, irr_d, isr_q, isr_d;
  logic [N_IRQ-1:0] imr_q, imr_d, irq_prev_q;

  logic [IDX_W-1:0] lp_q, lp_d, idx_q, idx_d;
  logic rsel_q, rsel_d, spur_q, spur_d;
  logic int_q, int_d, vld_q, vld_d, dir_q, dir_d;
  logic [7:0] vec_q, vec_d;

  logic inta_s1_q, inta_s2_q, inta_prev_q;
  logic inta_fall, inta_rise;

  logic             cand_found, isr_found;
  logic [IDX_W-1:0] cand_idx, isr_idx;

  logic             icw1_wr, ocw1, ocw2, ocw3;
  logic [IDX_W-1:0] lvl;
  logic             lvl_ok;
  logic             unused;

  function automatic int rank(
    input logic [IDX_W-1:0] i,
    input logic [IDX_W-1:0] l
  );
    return (int'(i) - int'(l) - 1 + 2 * N_IRQ) % N_IRQ;
  endfunction

  prio_rotate #(.N_IRQ(N_IRQ)) u_cand (
    .vec   (irr_q & ~imr_q),
    .lp    (lp_q),
    .found (cand_found),
    .idx   (cand_idx)
  );

  prio_rotate #(.N_IRQ(N_IRQ)) u_isr (
    .vec   (isr_q),
    .lp    (lp_q),
    .found (isr_found),
    .idx   (isr_idx)
  );

  assign inta_fall = inta_prev_q & ~inta_s2_q;
  assign inta_rise = ~inta_prev_q & inta_s2_q;

  assign icw1_wr = wr_en && !a0 && wdata[4];
  assign ocw1    = a0;
  assign ocw2    = !a0 && (wdata[4:3] == 2'b00);
  assign ocw3    = !a0 && (wdata[4:3] == 2'b01);
  assign lvl     = wdata[IDX_W-1:0];
  assign lvl_ok  = int'(lvl) < N_IRQ;

  always_comb begin
    init_st_d = init_st_q;
    ack_st_d  = ack_st_q;
    icw1_d    = icw1_q;
    icw2_d    = icw2_q;
    icw3_d    = icw3_q;
    icw4_d    = icw4_q;
    irr_d     = irr_q;
    isr_d     = isr_q;
    imr_d     = imr_q;
    lp_d      = lp_q;
    idx_d     = idx_q;
    rsel_d    = rsel_q;
    spur_d    = spur_q;
    int_d     = 1'b0;
    vld_d     = 1'b0;
    dir_d     = dir_q;
    vec_d     = vec_q;

    if (icw1_wr) begin
      icw1_d    = wdata;
      init_st_d = S_ICW2;
      ack_st_d  = A_IDLE;
      irr_d     = '0;
      isr_d     = '0;
      imr_d     = '0;
      lp_d      = LP_RST;
      dir_d     = 1'b0;
    end else begin
      if (icw1_q[ICW1_LTIM]) irr_d = irq_in;
      else irr_d = irr_q | (irq_in & ~irq_prev_q);

      if (wr_en) begin
        unique case (init_st_q)
          S_WAIT1: ;
          S_ICW2: if (a0) begin
            icw2_d = wdata;
            if (!icw1_q[ICW1_SNGL]) init_st_d = S_ICW3;
            else if (icw1_q[ICW1_IC4]) init_st_d = S_ICW4;
            else init_st_d = S_READY;
          end
          S_ICW3: if (a0) begin
            icw3_d    = wdata;
            init_st_d = icw1_q[ICW1_IC4] ? S_ICW4 : S_READY;
          end
          S_ICW4: if (a0) begin
            icw4_d    = wdata;
            init_st_d = S_READY;
          end
          S_READY: begin
            unique case (1'b1)
              ocw1: imr_d = wdata[N_IRQ-1:0];
              ocw2: begin
                // EOIs act on the ISR as it stood before this cycle.
                case (wdata[7:5])
                  EOI_NS: if (isr_found) isr_d[isr_idx] = 1'b0;
                  EOI_SP: if (lvl_ok) isr_d[lvl] = 1'b0;
                  ROT_NS: if (isr_found) begin
                    isr_d[isr_idx] = 1'b0;
                    lp_d = isr_idx;
                  end
                  SET_PRI: if (lvl_ok) lp_d = lvl;
                  default: ;
                endcase
              end
              ocw3: if (wdata[1]) rsel_d = wdata[0];
              default: ;
            endcase
          end
          default: init_st_d = S_WAIT1;
        endcase
      end

      unique case (ack_st_q)
        A_IDLE: if (inta_fall) begin
          ack_st_d = A_ACK1;
          if (cand_found) begin
            idx_d           = cand_idx;
            spur_d          = 1'b0;
            isr_d[cand_idx] = 1'b1;
            irr_d[cand_idx] = 1'b0;
          end else begin
            idx_d  = LP_RST;
            spur_d = 1'b1;
          end
        end
        A_ACK1: if (inta_fall) begin
          ack_st_d = A_ACK2;
          vec_d    = {icw2_q[7:IDX_W], idx_q};
          vld_d    = 1'b1;
          dir_d    = 1'b1;
        end
        A_ACK2: if (inta_rise) begin
          ack_st_d = A_IDLE;
          dir_d    = 1'b0;
          if (icw4_q[ICW4_AEOI] && !spur_q) isr_d[idx_q] = 1'b0;
        end
        default: ack_st_d = A_IDLE;
      endcase

      int_d = (init_st_q == S_READY) && (ack_st_q == A_IDLE) &&
              !inta_fall && cand_found &&
              (!isr_found || rank(cand_idx, lp_q) < rank(isr_idx, lp_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_st_q   <= S_WAIT1;
      ack_st_q    <= A_IDLE;
      icw1_q      <= '0;
      icw2_q      <= '0;
      icw3_q      <= '0;
      icw4_q      <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '0;
      irq_prev_q  <= '0;
      lp_q        <= LP_RST;
      idx_q       <= '0;
      rsel_q      <= 1'b0;
      spur_q      <= 1'b0;
      int_q       <= 1'b0;
      vld_q       <= 1'b0;
      dir_q       <= 1'b0;
      vec_q       <= '0;
      inta_s1_q   <= 1'b1;
      inta_s2_q   <= 1'b1;
      inta_prev_q <= 1'b1;
    end else begin
      init_st_q   <= init_st_d;
      ack_st_q    <= ack_st_d;
      icw1_q      <= icw1_d;
      icw2_q      <= icw2_d;
      icw3_q      <= icw3_d;
      icw4_q      <= icw4_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      irq_prev_q  <= irq_in;
      lp_q        <= lp_d;
      idx_q       <= idx_d;
      rsel_q      <= rsel_d;
      spur_q      <= spur_d;
      int_q       <= int_d;
      vld_q       <= vld_d;
      dir_q       <= dir_d;
      vec_q       <= vec_d;
      inta_s1_q   <= inta_n;
      inta_s2_q   <= inta_s1_q;
      inta_prev_q <= inta_s2_q;
    end
  end

  assign rdata = !rd_en ? 8'h00 :
                 a0     ? 8'(imr_q) :
                 rsel_q ? 8'(isr_q) : 8'(irr_q);

  assign int_out   = int_q;
  assign vec_out   = vec_q;
  assign vec_valid = vld_q;
  assign data_dir  = dir_q;
  assign init_done = (init_st_q == S_READY);

  assign unused = ^{icw1_q, icw2_q, icw3_q, icw4_q};

endmodule

// File: tb/tb_pic_ctrl_seq.sv
// Self-checking bench for pic_ctrl_seq: directed scenarios plus a
// randomized run against a rank-based priority model.
module tb_pic_ctrl_seq;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic a0 = 1'b0;
  logic rd_en = 1'b0;
  logic inta_n = 1'b1;
  logic [7:0] wdata = 8'h00;
  logic [N-1:0] irq_in = '0;
  logic [7:0] rdata, vec_out;
  logic int_out, vec_valid, data_dir, init_done;

  int n_tests = 0;
  int n_fail = 0;
  int vv_cnt = 0;
  logic [7:0] vv_last = 8'h00;

  pic_ctrl_seq #(.N_IRQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .a0(a0),
    .wdata(wdata), .rd_en(rd_en), .rdata(rdata),
    .irq_in(irq_in), .inta_n(inta_n), .int_out(int_out),
    .vec_out(vec_out), .vec_valid(vec_valid),
    .data_dir(data_dir), .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && vec_valid) begin
      vv_cnt  <= vv_cnt + 1;
      vv_last <= vec_out;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference priority: rank 0 is the index just above lp.
  function automatic int rank(input int i, input int lp);
    return (i - lp - 1 + 2 * N) % N;
  endfunction

  function automatic int best(input logic [7:0] v, input int lp);
    int b, br;
    b = -1;
    br = N;
    for (int i = 0; i < N; i++)
      if (v[i] && rank(i, lp) < br) begin
        br = rank(i, lp);
        b = i;
      end
    return b;
  endfunction

  function automatic logic int_exp(input logic [7:0] irr, imr, isr,
                                   input int lp);
    int c, s;
    c = best(irr & ~imr, lp);
    s = best(isr, lp);
    if (c < 0) return 1'b0;
    if (s < 0) return 1'b1;
    return rank(c, lp) < rank(s, lp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    a0 = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    a0 = 1'b0;
  endtask

  task automatic rd(input logic a, output logic [7:0] d);
    a0 = a;
    rd_en = 1'b1;
    #1;
    d = rdata;
    rd_en = 1'b0;
    a0 = 1'b0;
  endtask

  task automatic rd_isr(output logic [7:0] d);
    wr(1'b0, 8'h0B);
    rd(1'b0, d);
  endtask

  task automatic rd_irr(output logic [7:0] d);
    wr(1'b0, 8'h0A);
    rd(1'b0, d);
  endtask

  task automatic init(input logic [7:0] i1, i2, i4);
    irq_in = '0;
    repeat (2) tick();
    wr(1'b0, i1);
    wr(1'b1, i2);
    if (!i1[1]) wr(1'b1, 8'h00);
    if (i1[0]) wr(1'b1, i4);
  endtask

  task automatic pulse();
    inta_n = 1'b0;
    repeat (5) tick();
    inta_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic ack_seq(output logic [7:0] v, output int nv,
                         output logic dl, output logic dh);
    int c0;
    c0 = vv_cnt;
    pulse();
    inta_n = 1'b0;
    repeat (5) tick();
    dl = data_dir;
    inta_n = 1'b1;
    repeat (5) tick();
    dh = data_dir;
    v = vv_last;
    nv = vv_cnt - c0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    #3;
    n_tests++;
    if ({int_out, vec_valid, data_dir, init_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {int_out, vec_valid, data_dir, init_done});
    end
    n_tests++;
    if (vec_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_vec: got %h want 00", vec_out);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_imr: got %h want 00", d);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    int c0, lat;
    init(8'h13, 8'h20, 8'h01);
    n_tests++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done: got %b want 1", init_done);
    end
    irq_in[3] = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (int_out !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_int: got %b want 1", int_out);
    end
    pulse();
    n_tests++;
    if (int_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_int_drop: got %b want 0", int_out);
    end
    rd_isr(d);
    n_tests++;
    if (d !== 8'h08) begin
      n_fail++;
      $display("FAIL basic_isr: got %h want 08", d);
    end
    rd_irr(d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_irr: got %h want 00", d);
    end
    c0 = vv_cnt;
    lat = 0;
    inta_n = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (vec_valid) begin
        lat = c;
        break;
      end
    end
    n_tests++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want 3", lat);
    end
    n_tests++;
    if (vec_out !== 8'h23 || data_dir !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_vec: got %h/%b want 23/1", vec_out, data_dir);
    end
    repeat (3) tick();
    inta_n = 1'b1;
    repeat (5) tick();
    n_tests++;
    if (data_dir !== 1'b0 || vv_cnt - c0 != 1) begin
      n_fail++;
      $display("FAIL basic_end: dir %b pulses %0d want 0/1",
               data_dir, vv_cnt - c0);
    end
    wr(1'b0, 8'h20);
    rd_isr(d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_eoi: got %h want 00", d);
    end
  endtask

  task automatic test_init_seq();
    logic [7:0] d;
    logic [4:0] done;
    wr(1'b1, 8'h55);
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h55) begin
      n_fail++;
      $display("FAIL init_imr_set: got %h want 55", d);
    end
    wr(1'b0, 8'h11);
    done[0] = init_done;
    rd(1'b1, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL init_imr_clr: got %h want 00", d);
    end
    wr(1'b1, 8'h40);
    done[1] = init_done;
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h40);
    done[2] = init_done;
    wr(1'b1, 8'h00);
    done[3] = init_done;
    wr(1'b1, 8'h01);
    done[4] = init_done;
    n_tests++;
    if (done !== 5'b10000) begin
      n_fail++;
      $display("FAIL init_steps: got %b want 10000", done);
    end
  endtask

  task automatic test_mask();
    logic [7:0] v, d;
    int nv;
    logic dl, dh;
    wr(1'b1, 8'h04);
    irq_in = 8'h24;
    repeat (3) tick();
    ack_seq(v, nv, dl, dh);
    n_tests++;
    if (v !== 8'h45 || nv != 1 || dl !== 1'b1 || dh !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_vec: got %h n%0d %b%b want 45 n1 10",
               v, nv, dl, dh);
    end
    rd_irr(d);
    n_tests++;
    if (d !== 8'h04) begin
      n_fail++;
      $display("FAIL mask_irr: got %h want 04", d);
    end
    wr(1'b0, 8'h20);
    rd_isr(d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL mask_eoi: got %h want 00", d);
    end
  endtask

  task automatic test_nesting();
    logic [7:0] v, d;
    int nv;
    logic dl, dh;
    init(8'h13, 8'h20, 8'h01);
    irq_in[4] = 1'b1;
    repeat (3) tick();
    ack_seq(v, nv, dl, dh);
    irq_in[6] = 1'b1;
    repeat (4) tick();
    n_tests++;
    if (int_out !== 1'b0) begin
      n_fail++;
      $display("FAIL nest_low: got %b want 0", int_out);
    end
    irq_in[1] = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (int_out !== 1'b1) begin
      n_fail++;
      $display("FAIL nest_high: got %b want 1", int_out);
    end
    ack_seq(v, nv, dl, dh);
    rd_isr(d);
    n_tests++;
    if (d !== 8'h12 || v !== 8'h21) begin
      n_fail++;
      $display("FAIL nest_isr: got %h/%h want 12/21", d, v);
    end
    wr(1'b1, 8'h40);
    ack_seq(v, nv, dl, dh);
    rd_isr(d);
    n_tests++;
    if (v !== 8'h27 || d !== 8'h12) begin
      n_fail++;
      $display("FAIL nest_spur: got %h/%h want 27/12", v, d);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] v, d;
    int nv;
    logic dl, dh;
    init(8'h13, 8'h20, 8'h01);
    wr(1'b0, 8'hC3);
    irq_in = 8'h24;
    repeat (3) tick();
    ack_seq(v, nv, dl, dh);
    n_tests++;
    if (v !== 8'h25) begin
      n_fail++;
      $display("FAIL rot_first: got %h want 25", v);
    end
    wr(1'b0, 8'hA0);
    rd_isr(d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL rot_eoi: got %h want 00", d);
    end
    repeat (2) tick();
    ack_seq(v, nv, dl, dh);
    n_tests++;
    if (v !== 8'h22) begin
      n_fail++;
      $display("FAIL rot_second: got %h want 22", v);
    end
    irq_in[4] = 1'b1;
    repeat (4) tick();
    n_tests++;
    if (int_out !== int_exp(8'h10, 8'h00, 8'h04, 5)) begin
      n_fail++;
      $display("FAIL rot_nest: got %b want %b", int_out,
               int_exp(8'h10, 8'h00, 8'h04, 5));
    end
  endtask

  task automatic test_aeoi();
    logic [7:0] v, d;
    int nv;
    logic dl, dh;
    init(8'h13, 8'h20, 8'h03);
    irq_in[0] = 1'b1;
    repeat (3) tick();
    ack_seq(v, nv, dl, dh);
    rd_isr(d);
    n_tests++;
    if (v !== 8'h20 || d !== 8'h00) begin
      n_fail++;
      $display("FAIL aeoi_isr: got %h/%h want 20/00", v, d);
    end
    ack_seq(v, nv, dl, dh);
    rd_isr(d);
    n_tests++;
    if (v !== 8'h27 || nv != 1 || d !== 8'h00) begin
      n_fail++;
      $display("FAIL aeoi_spur: got %h n%0d isr %h want 27 n1 00",
               v, nv, d);
    end
  endtask

  task automatic test_random();
    logic [7:0] icw2, imr, irr, v, d, ev;
    logic aeoi;
    int lp, c, nv;
    logic dl, dh;
    for (int r = 0; r < 12; r++) begin
      icw2 = 8'($urandom) & 8'hF8;
      aeoi = 1'($urandom);
      lp = int'($urandom_range(0, N - 1));
      imr = 8'($urandom);
      irr = 8'($urandom);
      init(8'h13, icw2, aeoi ? 8'h03 : 8'h01);
      wr(1'b0, 8'hC0 | 8'(lp));
      wr(1'b1, imr);
      irq_in = irr;
      repeat (3) tick();
      for (int k = 0; k <= N; k++) begin
        c = best(irr & ~imr, lp);
        n_tests++;
        if (int_out !== int_exp(irr, imr, 8'h00, lp)) begin
          n_fail++;
          $display("FAIL rnd_int r%0d k%0d: got %b want %b",
                   r, k, int_out, int_exp(irr, imr, 8'h00, lp));
        end
        if (c < 0) break;
        ack_seq(v, nv, dl, dh);
        ev = icw2 | 8'(c);
        n_tests++;
        if (v !== ev || nv != 1) begin
          n_fail++;
          $display("FAIL rnd_vec r%0d k%0d: got %h n%0d want %h n1",
                   r, k, v, nv, ev);
        end
        irr[c] = 1'b0;
        if (!aeoi) wr(1'b0, 8'h20);
        repeat (2) tick();
      end
      rd_irr(d);
      n_tests++;
      if (d !== irr) begin
        n_fail++;
        $display("FAIL rnd_irr r%0d: got %h want %h", r, d, irr);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v, vb;
    int nv;
    logic dl, dh;
    init(8'h13, 8'h20, 8'h01);
    irq_in = 8'h02;
    repeat (3) tick();
    ack_seq(v, nv, dl, dh);
    irq_in = 8'h06;
    repeat (3) tick();
    pulse();
    vb = vec_out;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (vb !== 8'h21 || vec_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_vec: before %h after %h want 21/00",
               vb, vec_out);
    end
    n_tests++;
    if ({int_out, vec_valid, data_dir, init_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL rstmid_flags: got %b want 0000",
               {int_out, vec_valid, data_dir, init_done});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_init_seq();
    test_mask();
    test_nesting();
    test_rotation();
    test_aeoi();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_ctrl_seq.md
Name: pic_ctrl_seq

Overview:
- Parametrised, fully synchronous successor to the current interrupt control logic.
- Owns the IRR, ISR and IMR registers and the ICW1..ICW4 initialisation FSM.
- Decodes OCW1/OCW2/OCW3, runs the two-pulse INTA sequence and emits the vector.
- Adds over the current block: rotating priority, specific/non-specific EOI, auto-EOI, edge/level trigger, and status readback.
- Sits between the bus interface (data bus buffer / read-write logic) and the CPU INT/INTA pins.

Parameters:
N_IRQ, 8, number of request lines; legal range 2..8.
IDX_W, $clog2(N_IRQ), width of an IR index (localparam, derived).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  one-cycle write strobe from read-write logic.
a0  in  1  address bit selecting the command register.
wdata  in  8  write data.
rd_en  in  1  read strobe.
rdata  out  8  read data: IMR if a0=1; otherwise IRR or ISR as selected by OCW3.
irq_in  in  N_IRQ  request lines, synchronous to clk.
inta_n  in  1  CPU acknowledge, asynchronous, active-low.
int_out  out  1  interrupt request to CPU.
vec_out  out  8  vector byte.
vec_valid  out  1  one-cycle pulse when vec_out updates.
data_dir  out  1  1 = drive the bus toward the CPU.
init_done  out  1  initialisation complete.

Behaviour:
- Reset values:
  - All outputs 0.
  - IRR, ISR, IMR = 0; ICW registers = 0.
  - Lowest-priority pointer lp = N_IRQ-1, so IR0 is highest.
  - Init FSM in S_WAIT1; ack FSM in A_IDLE.
- Init FSM (advances on wr_en):
  - S_WAIT1: a write with a0=0 and wdata[4]=1 stores ICW1 and goes to S_ICW2.
  - S_ICW2 (a0=1): stores ICW2. Next state is S_ICW3 if ICW1[1]=0; else S_ICW4 if ICW1[0]=1; else S_READY.
  - S_ICW3 (a0=1): stores ICW3. Next state is S_ICW4 if ICW1[0]=1, else S_READY.
  - S_ICW4 (a0=1): stores ICW4, goes to S_READY.
  - An ICW1 write in any state restarts init: clears IMR, ISR, IRR, lp = N_IRQ-1, aborts any ack sequence, and moves to S_ICW2.
  - init_done = 1 only in S_READY.
  - int_out is forced to 0 while not in S_READY.
- Commands accepted only in S_READY:
  - OCW1 (a0=1): IMR = wdata[N_IRQ-1:0].
  - OCW2 (a0=0, wdata[4:3]=00), decoded on wdata[7:5]:
    - 001: non-specific EOI; clears the highest-priority set ISR bit.
    - 011: specific EOI; clears ISR[wdata[IDX_W-1:0]].
    - 101: rotate on non-specific EOI; clears that bit and sets lp to its index.
    - 110: set priority; lp = wdata[IDX_W-1:0].
    - All other codes ignored.
  - Any level index >= N_IRQ is ignored.
  - OCW3 (a0=0, wdata[4:3]=01): if wdata[1]=1, read select = wdata[0] (0 selects IRR, 1 selects ISR). Reset select = IRR.
- IRR:
  - ICW1[3]=0 (edge mode): IRR bit sets on a 0->1 transition of irq_in (previous-cycle register).
  - ICW1[3]=1 (level mode): IRR bit tracks irq_in while not being acknowledged.
- Priority order: starts at index (lp+1) mod N_IRQ and wraps.
- Pending candidate: highest-priority bit of IRR & ~IMR.
- int_out = 1 in A_IDLE when a candidate exists and outranks the highest set ISR bit (fully nested). Registered, so it appears 1 cycle after the IRR update.
- inta_n handling: passed through a 2-FF synchroniser; its falling edge is detected.
- Ack FSM:
  - A_IDLE, on 1st falling edge:
    - Latch idx = candidate, set ISR[idx], clear IRR[idx], drop int_out; go to A_ACK1.
    - If no candidate (spurious): idx = N_IRQ-1, ISR unchanged.
  - A_ACK1, on 2nd falling edge:
    - vec_out = {ICW2[7:IDX_W], idx}; vec_valid pulses 1 cycle; data_dir = 1; go to A_ACK2.
  - A_ACK2, on synchronised inta_n rising:
    - data_dir = 0.
    - If ICW4[1] (AEOI) and the ack was not spurious, clear ISR[idx].
    - Go to A_IDLE.
- Vector latency: vec_out changes 3 clk cycles after the raw inta_n falls (2 synchroniser stages + register).
- Simultaneous events:
  - An EOI evaluates the pre-cycle ISR; a same-cycle ISR set by the ack wins on the same bit.
  - IRR clear by ack wins over a same-cycle IRR set.
  - A write during A_ACK1/A_ACK2 is applied; idx is not re-resolved.
- Reset mid-sequence returns everything to reset values immediately (asynchronous).

Decomposition:
- Package pic_pkg holds:
  - Init-state and ack-state enumerations.
  - OCW2 opcode constants: EOI_NS=3'b001, EOI_SP=3'b011, ROT_NS=3'b101, SET_PRI=3'b110.
  - Field positions: ICW1_IC4=0, ICW1_SNGL=1, ICW1_LTIM=3, ICW4_AEOI=1.
- One sub-module, prio_rotate (N_IRQ): combinational, inputs vector and lp, outputs found and idx.
  - Instantiated twice: once for the pending candidate, once for the highest ISR bit.

Test Plan:
- Init with ICW1=0x13, ICW2=0x20, ICW4=0x01; raise irq_in[3]; two INTA pulses -> init_done=1, int_out=1, ISR=0x08, IRR=0x00, vec_out=0x23, vec_valid pulses once.
- Write ICW1=0x11; check FSM steps through ICW2 (0x40), ICW3 (0x00), ICW4 (0x01) -> init_done only after ICW4. A mid-sequence ICW1 restarts at S_ICW2.
- IMR=0x04, irq_in[2] and irq_in[5] rise -> ack vector = ICW2|5. Then OCW2=0x20 -> ISR=0x00.
- Nesting: IR4 in service, IR6 requests -> int_out stays 0. IR1 requests -> int_out=1; ack sets ISR=0x12.
- Rotation: OCW2=0xC3 (lp=3); IR2 and IR5 pending -> IR5 vectored first. Then OCW2=0xA0 -> lp=5, ISR cleared.
- AEOI (ICW4=0x03): after the 2nd INTA rises, ISR returns to 0. Spurious INTA with no request -> vec_out = ICW2|7 and ISR unchanged. rst_n low during A_ACK1 -> all outputs 0.
